// File: rtl/gcd_sched_pkg.sv
// rtl/gcd_sched_pkg.sv - shared types, default widths and helpers for gcd_sched
// Purpose: FSM state encoding, default parameter values and the id-width helper
//          used by gcd_sched and rr_arbiter.
// Ports:   none (package).
package gcd_sched_pkg;

  localparam int GCD_W = 8;
  localparam int GCD_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Width of a requester index; never below 1 so ports stay legal.
  function automatic int IDW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// rtl/gcd_sched_rr_arbiter.sv - combinational round-robin arbiter for gcd_sched
// Purpose: grants the first asserted request found searching ptr+1, ptr+2, ...
//          modulo N. The pointer register lives in the parent.
// Ports:   req     - request vector
//          ptr     - index granted last (search starts one above it)
//          enable  - when low no grant is issued
//          gnt     - one-hot grant, all-zero when nothing is granted
//          gnt_idx - binary index of the selected request
module rr_arbiter
  import gcd_sched_pkg::*;
#(
  parameter int  N    = GCD_N,
  localparam int ID_W = IDW(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    // Fallback: lowest asserted index overall (covers the wrap-around case).
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    // Preferred: lowest asserted index strictly above the pointer.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr))) begin
        gnt_idx = ID_W'(i);
      end
    end
    gnt = (enable && found) ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/gcd_sched.sv
// rtl/gcd_sched.sv - round-robin scheduler sharing one subtract/swap GCD engine
// Purpose: accepts operand pairs from N requesters, one at a time in
//          round-robin order, runs the iterative GCD and returns the result
//          tagged with the requester index.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          req_valid/ready   - per-requester handshake (req_ready one-hot)
//          req_a, req_b      - operands of requester i at [i*W +: W]
//          res_valid/ready   - result handshake
//          res_id, res_gcd   - requester index and gcd of its operands
//          res_iter          - swap/subtract step count (GCD_SCHED_ITER_CNT_EN only)
// Option:  define GCD_SCHED_ITER_CNT_EN to add the saturating step counter.
module gcd_sched
  import gcd_sched_pkg::*;
#(
  parameter int  N    = GCD_N,
  parameter int  W    = GCD_W,
  localparam int ID_W = IDW(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  output logic [N-1:0]    req_ready,
  input  logic            res_ready,
`ifdef GCD_SCHED_ITER_CNT_EN
  output logic [W-1:0]    res_iter,
`endif
  output logic            res_valid,
  output logic [ID_W-1:0] res_id,
  output logic [W-1:0]    res_gcd
);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q;
  logic [ID_W-1:0] id_q, ptr_q;
  logic            res_valid_q;
  logic [ID_W-1:0] gnt_idx;
  logic [W-1:0]    sel_a_d, sel_b_d;

  rr_arbiter #(.N(N)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .enable  (state_q == IDLE),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  // Operands of the granted requester; req_ready is one-hot so OR-select works.
  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        sel_a_d = sel_a_d | req_a[i*W +: W];
        sel_b_d = sel_b_d | req_b[i*W +: W];
      end
    end
  end

`ifdef GCD_SCHED_ITER_CNT_EN
  logic [W-1:0] iter_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else if (state_q == IDLE && (|req_ready)) begin
      iter_q <= '0;
    end else if (state_q == CALC && a_q != b_q && iter_q != '1) begin
      iter_q <= iter_q + W'(1);
    end
  end

  assign res_iter = iter_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      ptr_q       <= ID_W'(N - 1);
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            ptr_q <= gnt_idx;
            id_q  <= gnt_idx;
            b_q   <= sel_b_d;
            // gcd(x,0) = x and gcd(0,0) = 0: skip the loop entirely.
            if (sel_a_d == '0 || sel_b_d == '0) begin
              a_q         <= sel_a_d | sel_b_d;
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              a_q     <= sel_a_d;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (a_q == b_q) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end else if (a_q < b_q) begin
            a_q <= b_q;
            b_q <= a_q;
          end else begin
            a_q <= a_q - b_q;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = id_q;
  assign res_gcd   = a_q;

endmodule

// File: tb/tb_gcd_sched.sv
// tb/tb_gcd_sched.sv - directed self-checking bench for gcd_sched
module tb_gcd_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           res_ready;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [W-1:0]   res_gcd;
`ifdef GCD_SCHED_ITER_CNT_EN
  logic [W-1:0]   res_iter;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_sched #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_ready (res_ready),
`ifdef GCD_SCHED_ITER_CNT_EN
    .res_iter  (res_iter),
`endif
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_gcd   (res_gcd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input int a, input int b);
    req_a[idx*W +: W] = W'(a);
    req_b[idx*W +: W] = W'(b);
  endtask

  // Called at a negedge; returns at a negedge where a grant is visible (or timeout).
  task automatic wait_grant(input string tag, output int g);
    int n = 0;
    g = -1;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    check({tag, "_grant_seen"}, 32'(req_ready != '0), 1);
  endtask

  // Called at the negedge after the accept edge; lat = posedges after accept.
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!res_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_res_seen"}, 32'(res_valid), 1);
  endtask

  // exp_lat < 0 marks the zero-operand path: result must be up within 1 cycle.
  task automatic do_txn(input string tag, input int idx, input int a, input int b,
                        input int exp_gcd, input int exp_lat, input int exp_iter);
    int g, lat;
    set_req(idx, a, b);
    req_valid[idx] = 1'b1;
    #1;
    wait_grant(tag, g);
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    req_valid[idx] = 1'b0;
    #1;
    check({tag, "_ready_drop"}, 32'(req_ready), 0);
    wait_result(tag, lat);
    if (exp_lat < 0) check({tag, "_lat_le1"}, 32'(lat <= 1), 1);
    else             check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_gcd"}, 32'(res_gcd), exp_gcd);
    check({tag, "_id"}, 32'(res_id), idx);
`ifdef GCD_SCHED_ITER_CNT_EN
    check({tag, "_iter"}, 32'(res_iter), exp_iter);
`else
    if (exp_iter < 0) $display("bad iter argument");
`endif
    @(negedge clk);
  endtask

  initial begin
    int g, lat, bad;
    bit stable;
    int rr_a   [4] = '{12, 35, 20, 17};
    int rr_b   [4] = '{18, 14, 8, 5};
    int rr_gcd [4] = '{6, 7, 4, 1};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_res_gcd", 32'(res_gcd), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    @(negedge clk);

    // Single request, then zero/equal operands and extremes.
    do_txn("single", 0, 12, 18, 6, 5, 4);
    do_txn("zero_a", 1, 0, 35, 35, -1, 0);
    do_txn("zero_both", 2, 0, 0, 0, -1, 0);
    do_txn("equal", 3, 9, 9, 9, 1, 0);
    do_txn("big", 0, 255, 1, 1, 255, 254);
    do_txn("pow2", 1, 128, 64, 64, 2, 1);

    // Backpressure: result held with res_ready low while another request waits.
    res_ready = 1'b0;
    set_req(2, 20, 8);
    req_valid[2] = 1'b1;
    #1;
    wait_grant("bp", g);
    check("bp_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_result("bp", lat);
    check("bp_lat", lat, 5);
    set_req(0, 9, 9);
    req_valid[0] = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_gcd === 8'd4 && res_id === 2'd2 && req_ready === 4'b0))
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    res_ready = 1'b1;
    #1;
    check("bp_no_grant_hs", 32'(req_ready), 0);
    @(negedge clk);
    check("bp_grant_after", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_result("bp_next", lat);
    check("bp_next_lat", lat, 1);
    check("bp_next_gcd", 32'(res_gcd), 9);
    check("bp_next_id", 32'(res_id), 0);
    @(negedge clk);

    // Reset after three CALC cycles aborts the computation.
    set_req(2, 255, 1);
    req_valid[2] = 1'b1;
    #1;
    wait_grant("abort", g);
    check("abort_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_res_valid", 32'(res_valid), 0);
    check("abort_res_gcd", 32'(res_gcd), 0);
    check("abort_idle_ready", 32'(req_ready), 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    check("abort_no_result", bad, 0);

    // Round-robin with all requesters valid; index 0 first after reset.
    for (int i = 0; i < N; i++) set_req(i, rr_a[i], rr_b[i]);
    req_valid = '1;
    #1;
    check("rr_first_prio", 32'(req_ready), 32'b0001);
    for (int r = 0; r < 8; r++) begin
      wait_grant("rr", g);
      check("rr_order", g, r % 4);
      @(negedge clk);
      wait_result("rr", lat);
      check("rr_id", 32'(res_id), r % 4);
      check("rr_gcd", 32'(res_gcd), rr_gcd[r % 4]);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
